// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order circular issue queue between 4-wide decode and 2-wide issue
module issue_queue #(
    parameter int DEPTH       = 16,
    parameter int ISSUE_WIDTH = 2,
    parameter int ELEM_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [3:0][ELEM_W-1:0] issue_queue_element,
    input  logic [2:0]             issue_queue_push_number,
    output logic [2:0]             iq_size_left,
    output logic [1:0][ELEM_W-1:0] issue_element,
    output logic [1:0]             issue_valid_number,
    input  logic [1:0]             issue_pop_number
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [ELEM_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;
    logic [AW:0]       free;
    logic [2:0]        push_req;
    logic [AW:0]       push_req_w;
    logic [2:0]        push_eff;
    logic [1:0]        pop_eff;

    assign free = FULL - count;

    // Free space is reported from the registered count only, so pops in the
    // same cycle are never credited and there is no path back from issue.
    always_comb begin
        if (free >= (AW+1)'(4)) begin
            iq_size_left = 3'd4;
        end else begin
            iq_size_left = free[2:0];
        end
    end

    always_comb begin
        if (count >= (AW+1)'(ISSUE_WIDTH)) begin
            issue_valid_number = 2'(ISSUE_WIDTH);
        end else begin
            issue_valid_number = count[1:0];
        end
    end

    assign issue_element[0] = mem[head];
    assign issue_element[1] = mem[head + AW'(1)];

    // Over-length pushes are trimmed to the free space so live entries are never overwritten.
    always_comb begin
        push_req   = (issue_queue_push_number > 3'd4) ? 3'd4 : issue_queue_push_number;
        push_req_w = {{(AW-2){1'b0}}, push_req};
        push_eff   = 3'd0;
        pop_eff    = 2'd0;
        if (!flush) begin
            push_eff = (push_req_w > free) ? free[2:0] : push_req;
            pop_eff  = (issue_pop_number > issue_valid_number) ? issue_valid_number
                                                               : issue_pop_number;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_eff);
            tail  <= tail + AW'(push_eff);
            count <= count + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < push_eff) begin
                mem[tail + AW'(k)] <= issue_queue_element[k];
            end
        end
    end

    pop_over_valid: assert property (@(posedge clk) disable iff (rst)
        (flush || issue_pop_number <= issue_valid_number))
        else $warning("issue_queue: pop request exceeds presented entries, clamped");

    push_over_free: assert property (@(posedge clk) disable iff (rst)
        (flush || {{(AW-2){1'b0}}, issue_queue_push_number} <= free))
        else $warning("issue_queue: push request exceeds free space, excess dropped");

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking bench for issue_queue
module tb_issue_queue;

    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [3:0][31:0] elem_in = '0;
    logic [2:0]       push_n = 3'd0;
    logic [2:0]       iq_size_left;
    logic [1:0][31:0] issue_element;
    logic [1:0]       issue_valid_number;
    logic [1:0]       pop_n = 2'd0;

    int checks = 0;
    int failures = 0;
    int next_id = 0;

    logic [31:0] mq[$];
    int m_valid, m_pop, m_free, m_push;
    int c_sz, c_left, c_valid;

    issue_queue #(.DEPTH(DEPTH), .ISSUE_WIDTH(2), .ELEM_W(32)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .flush                   (flush),
        .issue_queue_element     (elem_in),
        .issue_queue_push_number (push_n),
        .iq_size_left            (iq_size_left),
        .issue_element           (issue_element),
        .issue_valid_number      (issue_valid_number),
        .issue_pop_number        (pop_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference queue: pops come off the front, pushes go on the back, free space
    // is judged on the occupancy before this cycle's pops.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            m_valid = (mq.size() < 2) ? mq.size() : 2;
            m_pop   = (int'(pop_n) < m_valid) ? int'(pop_n) : m_valid;
            m_free  = DEPTH - mq.size();
            m_push  = (int'(push_n) > 4) ? 4 : int'(push_n);
            if (m_push > m_free) m_push = m_free;
            repeat (m_pop) void'(mq.pop_front());
            for (int k = 0; k < m_push; k++) mq.push_back(elem_in[k]);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            c_sz    = mq.size();
            c_left  = (DEPTH - c_sz >= 4) ? 4 : DEPTH - c_sz;
            c_valid = (c_sz < 2) ? c_sz : 2;
            chk("model_size_left", iq_size_left, c_left);
            chk("model_valid", issue_valid_number, c_valid);
            for (int k = 0; k < c_valid; k++) chk("model_elem", issue_element[k], mq[k]);
        end
    end

    task automatic cyc(input int n, input int p, input bit f);
        for (int k = 0; k < 4; k++) elem_in[k] = 32'(next_id + k);
        push_n = 3'(n);
        pop_n  = 2'(p);
        flush  = f;
        next_id += n;
        @(posedge clk);
        #1;
        push_n = 3'd0;
        pop_n  = 2'd0;
        flush  = 1'b0;
        elem_in = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill14();
        cyc(4, 0, 0); cyc(4, 0, 0); cyc(4, 0, 0); cyc(2, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // mid-cycle async reset with 9 entries held
        next_id = 'h100;
        cyc(4, 0, 0); cyc(4, 0, 0); cyc(1, 0, 0);
        chk("t1_pre_left", iq_size_left, 4);
        chk("t1_pre_valid", issue_valid_number, 2);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_left", iq_size_left, 4);
        chk("t1_rst_valid", issue_valid_number, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // fill without pops
        next_id = 'h200;
        cyc(4, 0, 0); cyc(4, 0, 0); cyc(4, 0, 0);
        chk("t2_c12_left", iq_size_left, 4);
        chk("t2_c12_valid", issue_valid_number, 2);
        cyc(1, 0, 0);
        chk("t2_c13_left", iq_size_left, 3);
        cyc(3, 0, 0);
        chk("t2_c16_left", iq_size_left, 0);
        chk("t2_c16_valid", issue_valid_number, 2);
        chk("t2_head", issue_element[0], 'h200);
        repeat (8) cyc(0, 2, 0);
        chk("t2_drained", issue_valid_number, 0);

        // wrap-around with head/tail at 14
        do_reset();
        next_id = 'h300;
        fill14();
        repeat (7) cyc(0, 2, 0);
        next_id = 'hA0;
        cyc(4, 0, 0);
        chk("t3_e0_a", issue_element[0], 'hA0);
        chk("t3_e1_b", issue_element[1], 'hA1);
        cyc(0, 2, 0);
        chk("t3_e0_c", issue_element[0], 'hA2);
        chk("t3_e1_d", issue_element[1], 'hA3);
        cyc(0, 2, 0);
        chk("t3_empty", issue_valid_number, 0);
        chk("t3_left", iq_size_left, 4);

        // simultaneous push 2 / pop 2 at count 14
        do_reset();
        next_id = 'h400;
        fill14();
        chk("t4_pre_left", iq_size_left, 2);
        cyc(2, 2, 0);
        chk("t4_left", iq_size_left, 2);
        chk("t4_head", issue_element[0], 'h402);

        // flush with concurrent push and pop
        do_reset();
        next_id = 'h500;
        cyc(4, 0, 0); cyc(3, 0, 0);
        chk("t5_pre_valid", issue_valid_number, 2);
        cyc(4, 2, 1);
        chk("t5_left", iq_size_left, 4);
        chk("t5_valid", issue_valid_number, 0);
        cyc(1, 0, 0);
        chk("t5_after_valid", issue_valid_number, 1);
        chk("t5_after_head", issue_element[0], 'h50B);

        // over-pop clamps to one entry
        do_reset();
        next_id = 'h600;
        cyc(1, 0, 0);
        cyc(0, 2, 0);
        chk("t6_pop_valid", issue_valid_number, 0);
        cyc(2, 0, 0);
        chk("t6_pop_head", issue_element[0], 'h601);
        chk("t6_pop_next", issue_element[1], 'h602);

        // over-push keeps only the slots that fit
        do_reset();
        next_id = 'h700;
        fill14();
        cyc(4, 0, 0);
        chk("t6_push_left", iq_size_left, 0);
        repeat (7) cyc(0, 2, 0);
        chk("t6_push_valid", issue_valid_number, 2);
        chk("t6_push_e0", issue_element[0], 'h70E);
        chk("t6_push_e1", issue_element[1], 'h70F);
        cyc(0, 2, 0);
        chk("t6_push_empty", issue_valid_number, 0);
        chk("t6_push_left4", iq_size_left, 4);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
